// File: rtl/md_unit_pkg.sv
// Shared op codes, divider state encoding and op-class decode helpers for the
// multiply/divide unit and its controller.
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;
  localparam logic [3:0] MD_MFHI  = 4'd9;
  localparam logic [3:0] MD_MFLO  = 4'd10;
  localparam logic [3:0] MD_MTHI  = 4'd11;
  localparam logic [3:0] MD_MTLO  = 4'd12;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_SETUP,
    DIV_ITER,
    DIV_FIX
  } div_state_e;

  function automatic logic is_mult(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op inside {MD_MSUB, MD_MSUBU};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface md_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] S;
  logic [CNT_W-1:0] count;
  logic             busy;

  modport master (output A, B, op, cancel, input S, count, busy);
  modport slave  (input A, B, op, cancel, output S, count, busy);
endinterface

// File: rtl/md_divider.sv
// Iterative restoring divider: one setup cycle, WIDTH shift/subtract cycles,
// then one sign-fix cycle during which done_o is high and results are valid.
module md_divider
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int IW = $clog2(WIDTH);

  div_state_e       stateQ, stateD;
  logic [WIDTH-1:0] dvdQ, dvdD;
  logic [WIDTH-1:0] dvsQ, dvsD;
  logic [WIDTH-1:0] remQ, remD;
  logic [IW-1:0]    iterQ, iterD;
  logic             signedQ, signedD;
  logic             negQuoQ, negQuoD;
  logic             negRemQ, negRemD;
  logic             dbzQ, dbzD;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   diff;

  // dvdQ holds the raw dividend until setup, then doubles as the quotient shift register.
  always_comb begin
    stateD   = stateQ;
    dvdD     = dvdQ;
    dvsD     = dvsQ;
    remD     = remQ;
    iterD    = iterQ;
    signedD  = signedQ;
    negQuoD  = negQuoQ;
    negRemD  = negRemQ;
    dbzD     = dbzQ;
    remShift = {remQ, dvdQ[WIDTH-1]};
    diff     = remShift - {1'b0, dvsQ};
    case (stateQ)
      DIV_IDLE: begin
        if (start_i) begin
          dvdD    = dividend_i;
          dvsD    = divisor_i;
          signedD = signed_i;
          stateD  = DIV_SETUP;
        end
      end
      DIV_SETUP: begin
        negQuoD = signedQ & (dvdQ[WIDTH-1] ^ dvsQ[WIDTH-1]);
        negRemD = signedQ & dvdQ[WIDTH-1];
        dbzD    = (dvsQ == '0);
        if (signedQ && dvdQ[WIDTH-1]) dvdD = -dvdQ;
        if (signedQ && dvsQ[WIDTH-1]) dvsD = -dvsQ;
        remD    = '0;
        iterD   = IW'(WIDTH - 1);
        stateD  = DIV_ITER;
      end
      DIV_ITER: begin
        if (!diff[WIDTH]) begin
          remD = diff[WIDTH-1:0];
          dvdD = {dvdQ[WIDTH-2:0], 1'b1};
        end else begin
          remD = remShift[WIDTH-1:0];
          dvdD = {dvdQ[WIDTH-2:0], 1'b0};
        end
        if (iterQ == '0) stateD = DIV_FIX;
        else             iterD  = iterQ - 1'b1;
      end
      DIV_FIX: stateD = DIV_IDLE;
      default: stateD = DIV_IDLE;
    endcase
    if (abort_i) stateD = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= DIV_IDLE;
      dvdQ    <= '0;
      dvsQ    <= '0;
      remQ    <= '0;
      iterQ   <= '0;
      signedQ <= 1'b0;
      negQuoQ <= 1'b0;
      negRemQ <= 1'b0;
      dbzQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      dvdQ    <= dvdD;
      dvsQ    <= dvsD;
      remQ    <= remD;
      iterQ   <= iterD;
      signedQ <= signedD;
      negQuoQ <= negQuoD;
      negRemQ <= negRemD;
      dbzQ    <= dbzD;
    end
  end

  assign done_o        = (stateQ == DIV_FIX);
  assign quotient_o    = negQuoQ ? -dvdQ : dvdQ;
  assign remainder_o   = negRemQ ? -remQ : remQ;
  assign div_by_zero_o = dbzQ;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO; results land in HI/LO only on
// the edge where the in-flight countdown reaches zero.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic   clk,
  input  logic   reset,
  md_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(WIDTH + 2);

  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;
  logic [CNT_W-1:0]   countQ, countD;
  logic [2*WIDTH-1:0] prodQ, prodD;
  logic               isDivQ, isDivD;
  logic               accQ, accD;
  logic               subQ, subD;
  logic               launch;
  logic               opSigned;
  logic [2*WIDTH-1:0] aExt, bExt;
  logic [2*WIDTH-1:0] hiLo, multRes;
  logic               divDone, divDbz;
  logic [WIDTH-1:0]   divQuo, divRem;

  assign launch   = (is_mult(bus.op) | is_div(bus.op)) & (countQ == '0) & ~bus.cancel;
  assign opSigned = is_signed(bus.op);
  assign aExt     = {{WIDTH{opSigned & bus.A[WIDTH-1]}}, bus.A};
  assign bExt     = {{WIDTH{opSigned & bus.B[WIDTH-1]}}, bus.B};
  assign hiLo     = {hiQ, loQ};

  // Accumulate ops fold the product into HI/LO as they stand at commit, not at launch.
  always_comb begin
    if (!accQ)     multRes = prodQ;
    else if (subQ) multRes = hiLo - prodQ;
    else           multRes = hiLo + prodQ;
  end

  always_comb begin
    hiD    = hiQ;
    loD    = loQ;
    countD = countQ;
    prodD  = prodQ;
    isDivD = isDivQ;
    accD   = accQ;
    subD   = subQ;
    if (bus.cancel) begin
      countD = '0;
    end else if (countQ != '0) begin
      countD = countQ - 1'b1;
      if (countQ == CNT_W'(1)) begin
        if (!isDivQ) begin
          {hiD, loD} = multRes;
        end else if (divDone && !divDbz) begin
          hiD = divRem;
          loD = divQuo;
        end
      end
    end else if (launch) begin
      isDivD = is_div(bus.op);
      accD   = is_acc(bus.op);
      subD   = is_sub(bus.op);
      prodD  = aExt * bExt;
      countD = is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
    end else if (bus.op == MD_MTHI) begin
      hiD = bus.A;
    end else if (bus.op == MD_MTLO) begin
      loD = bus.A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiQ    <= '0;
      loQ    <= '0;
      countQ <= '0;
      prodQ  <= '0;
      isDivQ <= 1'b0;
      accQ   <= 1'b0;
      subQ   <= 1'b0;
    end else begin
      hiQ    <= hiD;
      loQ    <= loD;
      countQ <= countD;
      prodQ  <= prodD;
      isDivQ <= isDivD;
      accQ   <= accD;
      subQ   <= subD;
    end
  end

  md_divider #(.WIDTH(WIDTH)) u_divider (
    .clk           (clk),
    .reset         (reset),
    .start_i       (launch & is_div(bus.op)),
    .abort_i       (bus.cancel),
    .signed_i      (opSigned),
    .dividend_i    (bus.A),
    .divisor_i     (bus.B),
    .done_o        (divDone),
    .quotient_o    (divQuo),
    .remainder_o   (divRem),
    .div_by_zero_o (divDbz)
  );

  assign bus.S     = (bus.op == MD_MFHI) ? hiQ : loQ;
  assign bus.count = countQ;
  assign bus.busy  = (countQ != '0) | launch;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a vector table run back-to-back through a
// result scoreboard, plus hand-written cancel, busy-ignore and reset sequences.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int CW = 8;
  localparam int DL = W + 2;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[16];
  exp_t sbQ[$];

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W), .CNT_W(CW)) mdBus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdBus.slave)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic cncl);
    mdBus.op     = op;
    mdBus.A      = a;
    mdBus.B      = b;
    mdBus.cancel = cncl;
  endtask

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    applyStimulus(MD_MFHI, '0, '0, 1'b0);
    #1;
    hi = mdBus.S;
    applyStimulus(MD_MFLO, '0, '0, 1'b0);
    #1;
    lo = mdBus.S;
    applyStimulus(MD_NONE, '0, '0, 1'b0);
  endtask

  task automatic setHiLo(input logic [31:0] hi, input logic [31:0] lo);
    applyStimulus(MD_MTHI, hi, '0, 1'b0);
    tick();
    applyStimulus(MD_MTLO, lo, '0, 1'b0);
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
  endtask

  // Launch one op, follow the countdown each cycle, then score HI/LO.
  task automatic runVector(input string tag, input vec_t v);
    logic [31:0] hi, lo;
    exp_t e;
    sbQ.push_back('{v.expHi, v.expLo});
    applyStimulus(v.op, v.a, v.b, 1'b0);
    #1;
    checkOutput({tag, " busy@launch"}, 64'(mdBus.busy), 64'(v.lat > 0));
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
    for (int j = v.lat; j >= 0; j--) begin
      checkOutput({tag, " count"}, 64'(mdBus.count), 64'(j));
      if (j > 0) tick();
    end
    checkOutput({tag, " busy@done"}, 64'(mdBus.busy), 64'd0);
    readHiLo(hi, lo);
    e = sbQ.pop_front();
    checkOutput({tag, " HI"}, 64'(hi), 64'(e.hi));
    checkOutput({tag, " LO"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin : main
    logic [31:0] hi, lo;
    int budget;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MC};
    vecs[1]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DL};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL};
    vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DL};
    vecs[4]  = '{MD_MTHI,  32'd1,        32'd0,        32'd1,        32'h80000000, 0};
    vecs[5]  = '{MD_MTLO,  32'hFFFFFFFF, 32'd0,        32'd1,        32'hFFFFFFFF, 0};
    vecs[6]  = '{MD_MADDU, 32'd1,        32'd1,        32'd2,        32'd0,        MC};
    vecs[7]  = '{MD_MSUB,  32'd1,        32'd2,        32'd1,        32'hFFFFFFFE, MC};
    vecs[8]  = '{MD_MTLO,  32'd5,        32'd0,        32'd1,        32'd5,        0};
    vecs[9]  = '{MD_MTHI,  32'd9,        32'd0,        32'd9,        32'd5,        0};
    vecs[10] = '{MD_DIV,   32'd3,        32'd0,        32'd9,        32'd5,        DL};
    vecs[11] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[12] = '{MD_MADD,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 32'h00000000, MC};
    vecs[13] = '{MD_MSUBU, 32'd2,        32'd3,        32'hFFFFFFFD, 32'hFFFFFFFA, MC};
    vecs[14] = '{MD_DIVU,  32'd7,        32'd9,        32'd7,        32'd0,        DL};
    vecs[15] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DL};

    applyStimulus(MD_NONE, '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset count", 64'(mdBus.count), 64'd0);
    checkOutput("reset busy", 64'(mdBus.busy), 64'd0);
    readHiLo(hi, lo);
    checkOutput("reset HI", 64'(hi), 64'd0);
    checkOutput("reset LO", 64'(lo), 64'd0);

    for (int i = 0; i < 16; i++) runVector($sformatf("vec%0d", i), vecs[i]);

    // Cancel on the commit edge: no commit, and the cancelled mtlo is dropped.
    tick();
    setHiLo(32'd11, 32'd22);
    applyStimulus(MD_MULT, 32'd2, 32'd3, 1'b0);
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
    for (int j = 0; j < MC - 1; j++) tick();
    checkOutput("cancel pre count", 64'(mdBus.count), 64'd1);
    applyStimulus(MD_MTLO, 32'd3, '0, 1'b1);
    #1;
    checkOutput("cancel busy held", 64'(mdBus.busy), 64'd1);
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
    #1;
    checkOutput("cancel count", 64'(mdBus.count), 64'd0);
    checkOutput("cancel busy", 64'(mdBus.busy), 64'd0);
    readHiLo(hi, lo);
    checkOutput("cancel HI", 64'(hi), 64'd11);
    checkOutput("cancel LO", 64'(lo), 64'd22);

    // Ops presented mid-divide are ignored; mflo still returns the old LO.
    tick();
    setHiLo(32'd5, 32'd6);
    applyStimulus(MD_DIVU, 32'd50, 32'd5, 1'b0);
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(MD_MTLO, 32'd77, '0, 1'b0);
    tick();
    applyStimulus(MD_MULT, 32'd9, 32'd9, 1'b0);
    #1;
    checkOutput("ignore busy", 64'(mdBus.busy), 64'd1);
    tick();
    checkOutput("ignore count", 64'(mdBus.count), 64'(DL - 5));
    readHiLo(hi, lo);
    checkOutput("ignore HI busy", 64'(hi), 64'd5);
    checkOutput("ignore LO busy", 64'(lo), 64'd6);
    budget = 0;
    while (mdBus.count != '0 && budget < 100) begin
      tick();
      budget++;
    end
    checkOutput("ignore drain", 64'(mdBus.count), 64'd0);
    tick();
    checkOutput("ignore no relaunch", 64'(mdBus.count), 64'd0);
    readHiLo(hi, lo);
    checkOutput("ignore HI", 64'(hi), 64'd0);
    checkOutput("ignore LO", 64'(lo), 64'd10);

    // Reset mid-divide, then a fresh divu must complete normally.
    tick();
    applyStimulus(MD_DIV, 32'hFFFFFF9C, 32'd7, 1'b0);
    tick();
    applyStimulus(MD_NONE, '0, '0, 1'b0);
    for (int j = 0; j < 10; j++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset count", 64'(mdBus.count), 64'd0);
    readHiLo(hi, lo);
    checkOutput("midreset HI", 64'(hi), 64'd0);
    checkOutput("midreset LO", 64'(lo), 64'd0);
    runVector("postreset", '{MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DL});

    checkOutput("scoreboard empty", 64'(sbQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
